// File: rtl/multiplier_pkg.sv
// rtl/multiplier_pkg.sv - shared types and constants for the shift-add multiplier controller
//
// Holds the controller state enumeration and the default operand width
// used by multiplier_control and its iteration counter.
package multiplier_pkg;

  localparam int DEFAULT_WORD_LENGTH = 4;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    LOAD  = 3'd2,
    ITER  = 3'd3,
    DONE  = 3'd4
  } state_t;

endpackage

// File: rtl/iteration_counter.sv
// rtl/iteration_counter.sv - saturating iteration counter with terminal-count flag
//
// Ports:
//   clk      - rising-edge clock
//   reset    - asynchronous active-low reset, clears count
//   clear    - synchronous clear (wins over enable)
//   enable   - count one iteration this cycle
//   count    - iterations completed, never exceeds MAX_COUNT
//   terminal - high when this enabled cycle brings count to MAX_COUNT
module iteration_counter #(
  parameter int MAX_COUNT = 4,
  parameter int WIDTH     = $clog2(MAX_COUNT + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             enable,
  output logic [WIDTH-1:0] count,
  output logic             terminal
);

  localparam logic [WIDTH-1:0] LAST = WIDTH'(MAX_COUNT - 1);
  localparam logic [WIDTH-1:0] FULL = WIDTH'(MAX_COUNT);

  // Saturate at FULL so a stray enable can never wrap the count.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != FULL)) begin
      count <= count + WIDTH'(1);
    end
  end

  assign terminal = enable && (count == LAST);

endmodule

// File: rtl/multiplier_control.sv
// rtl/multiplier_control.sv - sequencer for a shift-add multiplier datapath
//
// Ports:
//   clk            - rising-edge clock
//   reset          - asynchronous active-low reset
//   start          - begin a multiply (only looked at in IDLE)
//   abort          - cancel an operation in CLEAR/LOAD/ITER
//   multiplier_bit - LSB of the multiplier shift register
//   clear_n        - product register synchronous clear, active low
//   load_en        - latch multiplicand and multiplier
//   acc_en         - product register enable
//   shift_en       - shift multiplicand left, multiplier right
//   busy           - high outside IDLE
//   done           - one-cycle pulse while the product is valid
//   count          - iterations completed in the current operation
module multiplier_control
  import multiplier_pkg::*;
#(
  parameter  int WORD_LENGTH = DEFAULT_WORD_LENGTH,
  localparam int COUNT_WIDTH = $clog2(WORD_LENGTH + 1)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   abort,
  input  logic                   multiplier_bit,
  output logic                   clear_n,
  output logic                   load_en,
  output logic                   acc_en,
  output logic                   shift_en,
  output logic                   busy,
  output logic                   done,
  output logic [COUNT_WIDTH-1:0] count
);

  state_t state;
  logic   cnt_clear;
  logic   cnt_enable;
  logic   last_iter;

  // Count is zeroed while the operation is being set up, so it reads 0 in
  // LOAD and during the first ITER cycle; an abort also zeroes it.
  assign cnt_clear  = (state == CLEAR) || (state == LOAD) ||
                      ((state == ITER) && abort);
  assign cnt_enable = (state == ITER) && !abort;

  iteration_counter #(
    .MAX_COUNT (WORD_LENGTH),
    .WIDTH     (COUNT_WIDTH)
  ) u_iteration_counter (
    .clk      (clk),
    .reset    (reset),
    .clear    (cnt_clear),
    .enable   (cnt_enable),
    .count    (count),
    .terminal (last_iter)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE:    if (start && !abort) state <= CLEAR;
        CLEAR:   state <= abort ? IDLE : LOAD;
        LOAD:    state <= abort ? IDLE : ITER;
        ITER: begin
          if (abort)          state <= IDLE;
          else if (last_iter) state <= DONE;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Output decode from state; acc_en in ITER follows the multiplier LSB
  // so the partial product is only added for set bits.
  always_comb begin
    clear_n  = 1'b1;
    load_en  = 1'b0;
    acc_en   = 1'b0;
    shift_en = 1'b0;
    busy     = 1'b1;
    done     = 1'b0;
    case (state)
      IDLE:  busy = 1'b0;
      CLEAR: begin
        clear_n = 1'b0;
        acc_en  = 1'b1;
      end
      LOAD:  load_en = 1'b1;
      ITER: begin
        shift_en = 1'b1;
        acc_en   = multiplier_bit;
      end
      DONE:  done = 1'b1;
      default: busy = 1'b0;
    endcase
  end

endmodule
